fifo_transaccion: RTL and testbench

- Synchronous FIFO that buffers transaction-layer words on each of the four arbiter ports.
- One instance per port in front of the arbiter: it supplies data_in_N and empty_pN, and takes pop_pN.
- One instance per port behind the arbiter: it takes data_out_N and push_pN, and returns almostfull_pN.
- First-word-fall-through: the head word is always visible, so the combinational arbiter can pop and forward it in the same cycle.

---
 rtl/fifo_transaccion_pkg.sv | 20 ++
 rtl/fifo_transaccion_memoria.sv | 46 ++++
 rtl/fifo_transaccion.sv | 115 +++++++++++
 tb/tb_fifo_transaccion.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_transaccion_pkg.sv
// ============================================================================
// Module   : fifo_transaccion_pkg
// Purpose  : Shared sizing constants for the per-port transaction FIFOs and
//            the arbiter that sits between them.
// Contents : DEF_FIFO_WORD_SIZE - transaction word width in bits
//            DEF_ADDR_WIDTH     - pointer width
//            DEF_DEPTH          - entries per FIFO (2**DEF_ADDR_WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_transaccion_pkg;

  localparam int DEF_FIFO_WORD_SIZE = 10;
  localparam int DEF_ADDR_WIDTH     = 3;
  localparam int DEF_DEPTH          = 2 ** DEF_ADDR_WIDTH;

endpackage : fifo_transaccion_pkg

`default_nettype wire

// File: rtl/fifo_transaccion_memoria.sv
// ============================================================================
// Module   : memoria_fifo
// Purpose  : Dual-port register file backing the transaction FIFO.
//            Synchronous write port, asynchronous (zero-latency) read port so
//            the FIFO can present its head word first-word-fall-through.
// Ports    : clk     - write clock
//            wr_en   - write strobe, wr_data stored at wr_addr on rising edge
//            wr_addr - write address
//            wr_data - write data
//            rd_addr - read address
//            rd_data - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memoria_fifo
  import fifo_transaccion_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = DEF_FIFO_WORD_SIZE,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [FIFO_WORD_SIZE-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [FIFO_WORD_SIZE-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is intentionally not reset: stale words are hidden by the
  // occupancy count in the parent.
  logic [FIFO_WORD_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : memoria_fifo

`default_nettype wire

// File: rtl/fifo_transaccion.sv
// ============================================================================
// Module   : fifo_transaccion
// Purpose  : First-word-fall-through synchronous FIFO buffering transaction
//            words on one arbiter port. Tracks occupancy, decodes status
//            flags combinationally from the count register and keeps a
//            sticky overflow/underflow error flag.
// Ports    : clk                 - clock, rising edge
//            reset_L             - asynchronous active-low reset
//            push / data_in      - write request and word
//            pop                 - retire the head word
//            umbral_almost_full  - almost_full when count >= this value
//            umbral_almost_empty - almost_empty when count <= this value
//            data_out            - head word (0 while empty)
//            empty, full         - count == 0, count == DEPTH
//            almost_full         - count >= umbral_almost_full
//            almost_empty        - count <= umbral_almost_empty
//            fifo_count          - occupancy 0..DEPTH
//            error               - sticky overflow/underflow flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_transaccion
  import fifo_transaccion_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = DEF_FIFO_WORD_SIZE,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  input  logic [ADDR_WIDTH:0]       umbral_almost_full,
  input  logic [ADDR_WIDTH:0]       umbral_almost_empty,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ADDR_WIDTH:0]       fifo_count,
  output logic                      error
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_cnt_zero = '0;
  localparam logic [ADDR_WIDTH:0]   c_cnt_one  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [ADDR_WIDTH:0]       r_count;
  logic                      r_error;

  logic                      w_rd_ok;
  logic                      w_wr_ok;
  logic                      w_bad_req;
  logic [FIFO_WORD_SIZE-1:0] w_rd_data;

  // A pop is only honoured with data present. A push is honoured with room
  // available, or when full but an accepted pop frees the slot on the same
  // edge (the write lands in the slot being vacated, since wr_ptr == rd_ptr).
  assign w_rd_ok   = pop && (r_count != c_cnt_zero);
  assign w_wr_ok   = push && ((r_count < c_depth) || w_rd_ok);
  assign w_bad_req = (push && !w_wr_ok) || (pop && !w_rd_ok);

  memoria_fifo #(
    .FIFO_WORD_SIZE (FIFO_WORD_SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_memoria_fifo (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - c_cnt_one;
      end
      if (w_bad_req) begin
        r_error <= 1'b1;
      end
    end
  end

  // Memory is never cleared, so mask the head word while nothing is stored.
  assign data_out     = (r_count != c_cnt_zero) ? w_rd_data : '0;
  assign empty        = (r_count == c_cnt_zero);
  assign full         = (r_count == c_depth);
  assign almost_full  = (r_count >= umbral_almost_full);
  assign almost_empty = (r_count <= umbral_almost_empty);
  assign fifo_count   = r_count;
  assign error        = r_error;

endmodule : fifo_transaccion

`default_nettype wire

// File: tb/tb_fifo_transaccion.sv
// ============================================================================
// Module   : tb_fifo_transaccion
// Purpose  : Directed self-checking bench for fifo_transaccion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_transaccion;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [3:0] umbral_almost_full;
  logic [3:0] umbral_almost_empty;
  logic [9:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fifo_count;
  logic       error;

  int vectors;
  int miscompares;

  fifo_transaccion dut (
    .clk                 (clk),
    .reset_L             (reset_L),
    .push                (push),
    .data_in             (data_in),
    .pop                 (pop),
    .umbral_almost_full  (umbral_almost_full),
    .umbral_almost_empty (umbral_almost_empty),
    .data_out            (data_out),
    .empty               (empty),
    .full                (full),
    .almost_full         (almost_full),
    .almost_empty        (almost_empty),
    .fifo_count          (fifo_count),
    .error               (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive request, wait for the edge, sample 1 time unit later.
  task automatic cyc(input logic p, input logic q, input logic [9:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_L     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    data_in     = '0;
    umbral_almost_full  = 4'd6;
    umbral_almost_empty = 4'd2;

    // ---- Reset state ----
    #3;
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_ae",       32'(almost_empty), 32'd1);
    chk("rst_af",       32'(almost_full),  32'd0);
    chk("rst_count",    32'(fifo_count),   32'd0);
    chk("rst_dout",     32'(data_out),     32'd0);
    chk("rst_error",    32'(error),        32'd0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    // ---- Fill 0x001..0x008 ----
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 10'(i));
      chk("fill_count", 32'(fifo_count),   32'(i));
      chk("fill_head",  32'(data_out),     32'h001);
      chk("fill_full",  32'(full),         32'(i == 8));
      chk("fill_af",    32'(almost_full),  32'(i >= 6));
      chk("fill_ae",    32'(almost_empty), 32'(i <= 2));
      chk("fill_err",   32'(error),        32'd0);
    end

    // Threshold above DEPTH: almost_full never asserts, even when full.
    umbral_almost_full = 4'd9;
    #1;
    chk("af_thr9", 32'(almost_full), 32'd0);
    umbral_almost_full = 4'd8;
    #1;
    chk("af_thr8", 32'(almost_full), 32'd1);
    umbral_almost_full = 4'd6;

    // ---- Overflow ----
    cyc(1'b1, 1'b0, 10'h3FF);
    chk("ovf_error", 32'(error),      32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_head",  32'(data_out),   32'h001);

    // ---- Drain: 0x001..0x008, 0x3FF never appears ----
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(data_out), 32'(i));
      cyc(1'b0, 1'b1, 10'h0);
      chk("drain_count", 32'(fifo_count),   32'(8 - i));
      chk("drain_af",    32'(almost_full),  32'((8 - i) >= 6));
      chk("drain_ae",    32'(almost_empty), 32'((8 - i) <= 2));
    end
    chk("drain_empty", 32'(empty),    32'd1);
    chk("drain_dout",  32'(data_out), 32'd0);
    chk("drain_err",   32'(error),    32'd1);

    // ---- Error is sticky until reset ----
    do_reset();
    chk("clr_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;

    // ---- Underflow, then push+pop while empty ----
    cyc(1'b0, 1'b1, 10'h0);
    chk("udf_error", 32'(error),      32'd1);
    chk("udf_count", 32'(fifo_count), 32'd0);
    cyc(1'b1, 1'b1, 10'h155);
    chk("pp_empty_count", 32'(fifo_count), 32'd1);
    chk("pp_empty_empty", 32'(empty),      32'd0);
    chk("pp_empty_dout",  32'(data_out),   32'h155);
    chk("pp_empty_err",   32'(error),      32'd1);

    // ---- Push+pop when full: wrap-around ----
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10'(i));
    chk("ppf_pre_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 10'h100);
    chk("ppf_count", 32'(fifo_count), 32'd8);
    chk("ppf_error", 32'(error),      32'd0);
    chk("ppf_head",  32'(data_out),   32'h002);
    for (int i = 2; i <= 8; i++) begin
      chk("ppf_drain", 32'(data_out), 32'(i));
      cyc(1'b0, 1'b1, 10'h0);
    end
    chk("ppf_last",       32'(data_out),   32'h100);
    chk("ppf_last_count", 32'(fifo_count), 32'd1);
    cyc(1'b0, 1'b1, 10'h0);
    chk("ppf_final_empty", 32'(empty), 32'd1);
    chk("ppf_final_err",   32'(error), 32'd0);

    // ---- Asynchronous reset mid-operation ----
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 10'(16 + i));
    chk("ar_pre_count", 32'(fifo_count), 32'd5);
    chk("ar_pre_head",  32'(data_out),   32'h011);
    cyc(1'b0, 1'b1, 10'h0);
    cyc(1'b0, 1'b1, 10'h0);
    cyc(1'b0, 1'b1, 10'h0);
    cyc(1'b0, 1'b1, 10'h0);
    cyc(1'b0, 1'b1, 10'h0);
    cyc(1'b0, 1'b1, 10'h0);   // underflow so the reset must clear error
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 10'(16 + i));
    chk("ar_pre_err", 32'(error), 32'd1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("ar_empty", 32'(empty),      32'd1);
    chk("ar_count", 32'(fifo_count), 32'd0);
    chk("ar_dout",  32'(data_out),   32'd0);
    chk("ar_error", 32'(error),      32'd0);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_idle_count", 32'(fifo_count), 32'd0);
    cyc(1'b1, 1'b0, 10'h2AA);
    chk("ar_push_dout",  32'(data_out),   32'h2AA);
    chk("ar_push_count", 32'(fifo_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_transaccion

`default_nettype wire
